// File: rtl/word_checker_pkg.sv
// Shared definitions for the deserializer minitest word checker: FSM state
// encoding and the default expected-word FIFO geometry.
package word_checker_pkg;

   localparam int FIFO_DEPTH = 16;
   localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

   typedef logic [1:0] state_t;

   localparam state_t HUNT   = 2'd0;
   localparam state_t SLIP   = 2'd1;
   localparam state_t LOCKED = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags and a combinational head word.
// Push is accepted when full if a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rd_ptr];

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/word_checker.sv
// Compares deserializer output words against the transmitter's expected words,
// hunting for alignment with BITSLIP pulses and counting errors once locked.
module word_checker
   import word_checker_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int SLIP_WAIT  = 8,
   parameter int LOCK_CNT   = 4,
   parameter int ERR_THRESH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             I_STB,
   input  logic [WIDTH-1:0] I_DAT,
   input  logic             D_STB,
   input  logic [WIDTH-1:0] D_DAT,
   output logic             BITSLIP,
   output logic             O_LOCKED,
   output logic [CNT_W-1:0] O_ERR_CNT,
   output logic             O_OVF,
   output logic             O_UNF,
   output logic [1:0]       dbg_state
);

   // Strobes carry no back-pressure: a word is offered for exactly the cycle
   // its STB is high and is either taken or flagged (OVF/UNF) in that cycle.

   logic [WIDTH-1:0] head;
   logic             full;
   logic             empty;
   logic             pop;
   logic             cmp_vld;
   logic             cmp_match;
   state_t           state;
   logic [7:0]       match_cnt;
   logic [7:0]       miss_cnt;
   logic [7:0]       slip_cnt;

   assign pop       = D_STB && !empty;
   assign O_LOCKED  = (state == LOCKED);
   assign dbg_state = state;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst_n     (RST),
      .push      (I_STB),
      .push_data (I_DAT),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= HUNT;
         BITSLIP   <= 1'b0;
         O_ERR_CNT <= '0;
         O_OVF     <= 1'b0;
         O_UNF     <= 1'b0;
         cmp_vld   <= 1'b0;
         cmp_match <= 1'b0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         slip_cnt  <= '0;
      end else begin
         BITSLIP   <= 1'b0;
         // Words popped while settling after a slip are drained but never judged.
         cmp_vld   <= pop && (state != SLIP);
         cmp_match <= (head == D_DAT);
         if (I_STB && full && !pop) O_OVF <= 1'b1;
         if (D_STB && empty)        O_UNF <= 1'b1;

         case (state)
            HUNT: begin
               if (cmp_vld) begin
                  if (cmp_match) begin
                     if (match_cnt == 8'(LOCK_CNT - 1)) begin
                        state     <= LOCKED;
                        match_cnt <= '0;
                        miss_cnt  <= '0;
                     end else begin
                        match_cnt <= match_cnt + 8'd1;
                     end
                  end else begin
                     match_cnt <= '0;
                     slip_cnt  <= '0;
                     BITSLIP   <= 1'b1;
                     state     <= SLIP;
                  end
               end
            end
            SLIP: begin
               if (slip_cnt == 8'(SLIP_WAIT - 1)) state <= HUNT;
               else slip_cnt <= slip_cnt + 8'd1;
            end
            LOCKED: begin
               if (cmp_vld) begin
                  if (cmp_match) begin
                     miss_cnt <= '0;
                  end else begin
                     if (O_ERR_CNT != '1) O_ERR_CNT <= O_ERR_CNT + CNT_W'(1);
                     if (miss_cnt == 8'(ERR_THRESH - 1)) begin
                        state     <= HUNT;
                        match_cnt <= '0;
                        miss_cnt  <= '0;
                     end else begin
                        miss_cnt <= miss_cnt + 8'd1;
                     end
                  end
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_word_checker.sv
// Directed bench for word_checker: counter streams with a rotating
// deserializer model, error injection, FIFO bounds and async reset.
module tb_word_checker;
   import word_checker_pkg::*;

   localparam int SLIP_WAIT = 8;

   logic        CLK;
   logic        RST;
   logic        I_STB;
   logic [7:0]  I_DAT;
   logic        D_STB;
   logic [7:0]  D_DAT;
   logic        BITSLIP;
   logic        O_LOCKED;
   logic [15:0] O_ERR_CNT;
   logic        O_OVF;
   logic        O_UNF;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_pass   = 0;
   int i_word   = 0;
   int rot      = 0;
   int bad_lo   = 1000;
   int bad_hi   = 1000;
   int slips    = 0;
   int last_slip = 0;
   int cyc      = 0;

   word_checker #(
      .WIDTH      (8),
      .DEPTH      (16),
      .SLIP_WAIT  (SLIP_WAIT),
      .LOCK_CNT   (4),
      .ERR_THRESH (4),
      .CNT_W      (16)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .I_STB     (I_STB),
      .I_DAT     (I_DAT),
      .D_STB     (D_STB),
      .D_DAT     (D_DAT),
      .BITSLIP   (BITSLIP),
      .O_LOCKED  (O_LOCKED),
      .O_ERR_CNT (O_ERR_CNT),
      .O_OVF     (O_OVF),
      .O_UNF     (O_UNF),
      .dbg_state (dbg_state)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [7:0] rotl(input logic [7:0] x, input int r);
      return (x << r) | (x >> (8 - r));
   endfunction

   // One clock: drive after a falling edge, sample at the next falling edge.
   task automatic cycle(input logic istb, input logic [7:0] idat,
                        input logic dstb, input logic [7:0] ddat);
      I_STB = istb;
      I_DAT = idat;
      D_STB = dstb;
      D_DAT = ddat;
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
      if (BITSLIP) begin
         slips++;
         if (slips > 1) check("slip_gap", 32'(cyc - last_slip >= SLIP_WAIT), 32'd1);
         last_slip = cyc;
         rot = (rot + 7) % 8;
      end
   endtask

   // Transmitter counter with the deserializer three words behind it.
   task automatic stream(input int n);
      for (int i = 0; i < n; i++) begin
         logic [7:0] dw;
         logic       dstb;
         dstb = (i_word >= 3);
         dw   = 8'(i_word - 3);
         if (int'(dw) >= bad_lo && int'(dw) <= bad_hi) dw = dw ^ 8'h01;
         cycle(1'b1, 8'(i_word), dstb, rotl(dw, rot));
         i_word++;
      end
   endtask

   task automatic do_reset();
      RST   = 1'b0;
      I_STB = 1'b0;
      I_DAT = '0;
      D_STB = 1'b0;
      D_DAT = '0;
      repeat (2) @(negedge CLK);
      RST    = 1'b1;
      i_word = 0;
      rot    = 0;
      bad_lo = 1000;
      bad_hi = 1000;
      slips  = 0;
      cyc    = 0;
   endtask

   initial begin
      do_reset();
      check("rst_locked", 32'(O_LOCKED), 32'd0);
      check("rst_err",    32'(O_ERR_CNT), 32'd0);
      check("rst_flags",  32'({BITSLIP, O_OVF, O_UNF}), 32'd0);
      check("rst_state",  32'(dbg_state), 32'(HUNT));

      // Aligned stream: lock after the 4th registered match.
      stream(7);
      check("align_pre_lock", 32'(O_LOCKED), 32'd0);
      stream(1);
      check("align_lock", 32'(O_LOCKED), 32'd1);
      stream(248);
      check("align_locked_end", 32'(O_LOCKED), 32'd1);
      check("align_err", 32'(O_ERR_CNT), 32'd0);
      check("align_slips", 32'(slips), 32'd0);

      // Misaligned by 3: three slips then lock.
      do_reset();
      rot = 3;
      stream(256);
      check("mis_slips", 32'(slips), 32'd3);
      check("mis_locked", 32'(O_LOCKED), 32'd1);
      check("mis_err", 32'(O_ERR_CNT), 32'd0);

      // Single corrupted word while locked.
      do_reset();
      bad_lo = 8'h55;
      bad_hi = 8'h55;
      stream(8'h60);
      check("single_err", 32'(O_ERR_CNT), 32'd1);
      check("single_locked", 32'(O_LOCKED), 32'd1);
      check("single_slips", 32'(slips), 32'd0);

      // Burst of four: re-hunt, then the next mismatch slips.
      do_reset();
      bad_lo = 8'h80;
      bad_hi = 8'h83;
      stream(8'h88);
      check("burst_err", 32'(O_ERR_CNT), 32'd4);
      check("burst_locked", 32'(O_LOCKED), 32'd0);
      check("burst_state", 32'(dbg_state), 32'(HUNT));
      check("burst_no_slip", 32'(slips), 32'd0);
      bad_lo = 8'h85;
      bad_hi = 8'h85;
      stream(2);
      check("burst_slip", 32'(slips), 32'd1);
      check("burst_slip_state", 32'(dbg_state), 32'(SLIP));
      check("burst_err_hold", 32'(O_ERR_CNT), 32'd4);

      // FIFO bounds.
      do_reset();
      for (int j = 0; j < 16; j++) cycle(1'b1, 8'(j), 1'b0, 8'h00);
      check("fifo_full_no_ovf", 32'(O_OVF), 32'd0);
      cycle(1'b1, 8'd16, 1'b1, 8'd0);
      check("fifo_pushpop_full", 32'(O_OVF), 32'd0);
      cycle(1'b1, 8'd17, 1'b0, 8'h00);
      check("fifo_ovf", 32'(O_OVF), 32'd1);
      for (int j = 1; j <= 16; j++) cycle(1'b0, 8'h00, 1'b1, 8'(j));
      check("fifo_no_unf", 32'(O_UNF), 32'd0);
      check("fifo_err", 32'(O_ERR_CNT), 32'd0);
      check("fifo_locked", 32'(O_LOCKED), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 8'h11);
      check("fifo_unf", 32'(O_UNF), 32'd1);
      cycle(1'b1, 8'hA5, 1'b1, 8'hA5);
      cycle(1'b0, 8'h00, 1'b1, 8'h00);
      cycle(1'b0, 8'h00, 1'b0, 8'h00);
      check("fifo_queued_on_unf", 32'(O_ERR_CNT), 32'd1);
      check("fifo_ovf_sticky", 32'(O_OVF), 32'd1);

      // Async reset while locked.
      do_reset();
      bad_lo = 5;
      bad_hi = 5;
      stream(20);
      check("pre_rst_locked", 32'(O_LOCKED), 32'd1);
      check("pre_rst_err", 32'(O_ERR_CNT), 32'd1);
      @(posedge CLK);
      #2;
      RST = 1'b0;
      #1;
      check("arst_locked", 32'(O_LOCKED), 32'd0);
      check("arst_err", 32'(O_ERR_CNT), 32'd0);
      check("arst_flags", 32'({BITSLIP, O_OVF, O_UNF}), 32'd0);
      check("arst_state", 32'(dbg_state), 32'(HUNT));
      @(negedge CLK);
      do_reset();
      stream(8);
      check("relock", 32'(O_LOCKED), 32'd1);
      check("relock_err", 32'(O_ERR_CNT), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
